// File: rtl/cla_pkg.sv
// Shared defaults, id width and scheduler FSM encoding for the carry-lookahead
// adder scheduler and its arbiter.
package cla_pkg;

  localparam int W_DEF     = 128;
  localparam int N_REQ_DEF = 4;
  localparam int LAT_DEF   = 4;
  localparam int ID_W      = $clog2(N_REQ_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/cla_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so ptr sits at bit 0,
// isolate the lowest set bit, then rotate the grant back.
module cla_rr_arbiter
  import cla_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant
);

  logic [N_REQ-1:0] req_rot;
  logic [N_REQ-1:0] gnt_rot;

  // N_REQ is a power of two, so IDW-bit index arithmetic wraps modulo N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [IDW-1:0] src_idx;
    logic [IDW-1:0] dst_idx;
    assign src_idx     = IDW'(gi) + ptr;
    assign dst_idx     = IDW'(gi) - ptr;
    assign req_rot[gi] = req[src_idx];
    assign grant[gi]   = gnt_rot[dst_idx];
  end

  assign gnt_rot = req_rot & (~req_rot + N_REQ'(1));

endmodule

// File: rtl/cla_sched.sv
// Round-robin scheduler feeding a shared pipelined adder; a valid+id tag pipe
// follows each operation so its result is routed back to the right requester.
module cla_sched
  import cla_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int N_REQ = N_REQ_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ-1:0]   req_cin,
  output logic               add_valid,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  output logic               add_cin,
  input  logic [W-1:0]       add_sum,
  input  logic               add_cout,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_sum,
  output logic               rsp_cout,
  output logic               busy
);

  localparam int IDW   = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LAT + 3);

  state_t           state_reg;
  state_t           state_next;
  logic [IDW-1:0]   ptr_reg;
  logic [N_REQ-1:0] grant;
  logic             grant_en;
  logic             accept;
  logic             resp;
  logic [IDW-1:0]   grant_id;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic             sel_cin;
  logic [LAT:0]     tag_vld_reg;
  logic [IDW-1:0]   tag_id_reg [LAT+1];
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [N_REQ-1:0] rsp_valid_next;

  cla_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  assign grant_en  = !rst && (state_reg == ST_RUN) && en;
  assign req_ready = grant_en ? grant : '0;
  assign accept    = |req_ready;
  assign resp      = |rsp_valid;
  assign busy      = (state_reg != ST_IDLE) || (cnt_reg != '0);

  // grant is one-hot, so the mux collapses to a single matching slice.
  always_comb begin
    grant_id = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_cin  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_id = IDW'(i);
        sel_a    = req_a[i*W +: W];
        sel_b    = req_b[i*W +: W];
        sel_cin  = req_cin[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg   <= '0;
      add_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
    end else begin
      add_valid <= accept;
      if (accept) begin
        ptr_reg <= grant_id + 1'b1;
        add_a   <= sel_a;
        add_b   <= sel_b;
        add_cin <= sel_cin;
      end
    end
  end

  // Stage k of the tag pipe lines up with the adder in cycle accept+1+k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_reg <= '0;
    end else begin
      tag_vld_reg <= {tag_vld_reg[LAT-1:0], accept};
    end
  end

  always_ff @(posedge clk) begin
    tag_id_reg[0] <= grant_id;
    for (int k = 1; k <= LAT; k++) begin
      tag_id_reg[k] <= tag_id_reg[k-1];
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
    assign rsp_valid_next[gi] = tag_vld_reg[LAT] && (tag_id_reg[LAT] == IDW'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid_next;
      if (tag_vld_reg[LAT]) begin
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
      end
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (accept && !resp) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (!accept && resp) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (en) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!en) state_next = (cnt_next == '0) ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (en) begin
          state_next = ST_RUN;
        end else if (tag_vld_reg == '0) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

endmodule

// File: tb/tb_cla_sched.sv
// Randomized scoreboard bench for cla_sched with a behavioural pipelined adder.
module tb_cla_sched;
  import cla_pkg::*;

  localparam int W   = 128;
  localparam int N   = 4;
  localparam int LAT = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic           add_valid;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           busy;

  always #5 clk = ~clk;

  cla_sched #(.W(W), .N_REQ(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .busy(busy)
  );

  // External adder: result appears LAT cycles after the operands.
  logic [W:0] add_pipe [LAT];
  always @(posedge clk) begin
    add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
    for (int k = 1; k < LAT; k++) add_pipe[k] <= add_pipe[k-1];
  end
  assign add_sum  = add_pipe[LAT-1][W-1:0];
  assign add_cout = add_pipe[LAT-1][W];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  typedef struct {
    int         id;
    logic [W:0] res;
    int         due;
  } exp_t;
  exp_t q[$];

  // Monitor: reference round-robin pointer, starvation tracking, scoreboard.
  int           mptr;
  int           wait_cnt [N];
  int           eid;
  int           gid;
  int           jdx;
  int           acc_total;
  int           rsp_total;
  exp_t         mon_e;
  logic [N-1:0] mon_acc;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mptr = 0;
      acc_total = 0;
      rsp_total = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      if (rsp_valid != '0) begin
        rsp_total++;
        if (q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 0);
        end else begin
          mon_e = q.pop_front();
          check("rsp_id", rsp_valid, 1 << mon_e.id);
          check("rsp_sum", {rsp_cout, rsp_sum}, mon_e.res);
          check("rsp_latency", cyc, mon_e.due);
        end
      end
      mon_acc = req_valid & req_ready;
      if (req_ready != '0) begin
        check("ready_subset", req_ready & ~req_valid, 0);
        eid = -1;
        for (int k = 0; k < N; k++) begin
          jdx = (mptr + k) % N;
          if (eid < 0 && req_valid[jdx]) eid = jdx;
        end
        check("rr_grant", req_ready, 1 << eid);
        gid = 0;
        for (int i = N - 1; i >= 0; i--) if (mon_acc[i]) gid = i;
        acc_total++;
        q.push_back('{id: gid,
                      res: {1'b0, req_a[gid*W +: W]} + {1'b0, req_b[gid*W +: W]} + (W+1)'(req_cin[gid]),
                      due: cyc + LAT + 2});
        check("starvation", (wait_cnt[gid] <= N - 1), 1);
        for (int i = 0; i < N; i++) begin
          if (i == gid || !req_valid[i]) wait_cnt[i] = 0;
          else wait_cnt[i]++;
        end
        mptr = (gid + 1) % N;
      end else begin
        for (int i = 0; i < N; i++) if (!req_valid[i]) wait_cnt[i] = 0;
      end
    end
  end

  // Driver
  logic [N-1:0] renew;
  logic [N-1:0] g;
  int           nr;

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
    req_valid[i]    = 1'b1;
  endtask

  task automatic new_ops(input int i);
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int k = 0; k < W / 32; k++) begin
      a[k*32 +: 32] = $urandom;
      b[k*32 +: 32] = $urandom;
    end
    case ($urandom_range(0, 7))
      0: a = '1;
      1: b = '1;
      2: begin a = '1; b = '0; end
      default: ;
    endcase
    set_ops(i, a, b, 1'($urandom_range(0, 1)));
  endtask

  task automatic tick(output logic [N-1:0] gr);
    @(negedge clk);
    gr = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (gr[i]) begin
        if (renew[i]) new_ops(i);
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    en = 1'b0;
    req_valid = '0;
    renew = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) tick(g);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    req_valid = '1;
    renew = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    repeat (2) @(negedge clk);
    check("ready_in_rst", req_ready, 0);
    check("busy_rst", busy, 0);
    check("rsp_valid_rst", rsp_valid, 0);
    check("add_valid_rst", add_valid, 0);
    check("add_a_rst", add_a, 0);
    check("rsp_sum_rst", {rsp_cout, rsp_sum}, 0);

    // Single request: 1 + all-ones + 0 -> sum 0, carry 1, six cycles later.
    do_reset();
    en = 1'b1;
    tick(g);
    set_ops(2, W'(1), '1, 1'b0);
    tick(g);
    check("single_grant", g, 4'b0100);
    @(negedge clk);
    check("add_valid_issue", add_valid, 1);
    check("add_a_issue", add_a, 1);
    check("add_b_issue", add_b, {1'b0, {W{1'b1}}});
    @(negedge clk);
    check("add_valid_idle", add_valid, 0);
    check("add_a_hold", add_a, 1);
    idle_cycles(8);

    // Continuous requests on all ports from ptr 0.
    do_reset();
    en = 1'b1;
    renew = '1;
    for (int i = 0; i < N; i++) new_ops(i);
    tick(g);
    check("idle_no_grant", g, 0);
    for (int k = 0; k < 6; k++) begin
      tick(g);
      check("burst_grant", g, 1 << (k % N));
    end
    renew = '0;
    req_valid = '0;
    idle_cycles(10);

    // req_valid=1010 starting from ptr 2.
    do_reset();
    en = 1'b1;
    new_ops(1);
    tick(g);
    tick(g);
    check("ptr_setup_grant", g, 4'b0010);
    renew = 4'b1010;
    new_ops(1);
    new_ops(3);
    tick(g);
    check("rr1010_a", g, 4'b1000);
    tick(g);
    check("rr1010_b", g, 4'b0010);
    tick(g);
    check("rr1010_c", g, 4'b1000);
    renew = '0;
    req_valid = '0;
    idle_cycles(10);

    // Drop en after three accepts and watch the drain.
    do_reset();
    en = 1'b1;
    renew = '1;
    for (int i = 0; i < N; i++) new_ops(i);
    tick(g);
    for (int k = 0; k < 3; k++) tick(g);
    en = 1'b0;
    renew = '0;
    @(negedge clk);
    check("drain_ready_off", req_ready, 0);
    @(negedge clk);
    check("drain_state", dut.state_reg, ST_DRAIN);
    req_valid = '0;
    nr = 0;
    for (int k = 0; k < 20 && nr < 3; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) nr++;
    end
    check("drain_rsp_count", nr, 3);
    check("drain_busy_last", busy, 1);
    @(negedge clk);
    check("drain_busy_fall", busy, 0);
    check("drain_idle", dut.state_reg, ST_IDLE);

    // Reset with operations in flight.
    do_reset();
    en = 1'b1;
    renew = '1;
    for (int i = 0; i < N; i++) new_ops(i);
    tick(g);
    for (int k = 0; k < 3; k++) tick(g);
    rst = 1'b1;
    req_valid = '0;
    renew = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("rst_discard", rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    new_ops(2);
    new_ops(3);
    tick(g);
    check("post_rst_grant", g, 4'b0100);
    req_valid = '0;
    idle_cycles(10);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      en = ($urandom_range(0, 15) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) new_ops(i);
      end
      tick(g);
    end
    req_valid = '0;
    en = 1'b0;
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    @(negedge clk);
    check("final_busy", busy, 0);
    check("final_queue_empty", q.size(), 0);
    check("final_acc_eq_rsp", rsp_total, acc_total);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/cla_sched.md
CLA_SCHED -- requirements
Module: cla_sched

Interface
REQ-001 SHALL have parameters: W, default 128, operand width; N_REQ, default 4, requester count (power of two, >=2); LAT, default 4, adder pipeline latency in cycles.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  grant enable
- req_valid  in  N_REQ  per-requester request
- req_ready  out  N_REQ  one-hot grant, accept when valid&ready
- req_a  in  N_REQ*W  operand A, slice i = requester i
- req_b  in  N_REQ*W  operand B, slice i = requester i
- req_cin  in  N_REQ  carry-in, bit i = requester i
- add_valid  out  1  operands valid to adder
- add_a  out  W  adder operand A
- add_b  out  W  adder operand B
- add_cin  out  1  adder carry-in
- add_sum  in  W  adder sum, LAT cycles after operands
- add_cout  in  1  adder carry-out
- rsp_valid  out  N_REQ  one-hot response strobe
- rsp_sum  out  W  response sum
- rsp_cout  out  1  response carry-out
- busy  out  1  any operation in flight or FSM not IDLE

Function
REQ-003 SHALL grant at most one requester per cycle, round-robin; the search starts at pointer ptr.
REQ-004 After a grant to i, ptr SHALL become (i+1) mod N_REQ; with no grant, ptr SHALL hold.
REQ-005 req_ready SHALL be combinational from req_valid, en and state; req_ready[i] SHALL be high only when req_valid[i] is high.
REQ-006 Requesters SHALL NOT make req_valid depend on req_ready.
REQ-007 An operation accepted in cycle t SHALL drive add_valid, add_a, add_b and add_cin from registers in cycle t+1.
REQ-008 For an operation accepted in cycle t, add_sum SHALL be sampled in cycle t+1+LAT.
REQ-009 rsp_valid[i], rsp_sum and rsp_cout SHALL be registered and valid in cycle t+LAT+2; total latency is LAT+2.
REQ-010 The requester id SHALL travel in a valid+id tag shift register of depth LAT+1.
REQ-011 Responses SHALL return in acceptance order, with no backpressure.
REQ-012 Throughput SHALL be one operation per cycle, with no bubbles under continuous requests.
REQ-013 FSM states SHALL be:
- IDLE: en=0, nothing in flight; goes to RUN when en=1.
- RUN: grants allowed; when en=0, goes to IDLE if nothing is in flight or will be in flight next cycle, otherwise to DRAIN.
- DRAIN: no grants; goes to IDLE when the tag pipeline is empty; goes to RUN if en=1 (en has priority).
REQ-014 An in-flight counter (0..LAT+2) SHALL increment on accept and decrement on response; on the same cycle it SHALL hold.
REQ-015 busy SHALL equal (state!=IDLE) or (counter!=0).
REQ-016 When add_valid=0, add_a, add_b and add_cin SHALL hold their previous values.
REQ-017 rsp_sum and rsp_cout SHALL be don't-care when rsp_valid=0.

Reset
REQ-018 rst SHALL asynchronously set: state IDLE, ptr 0, counter 0, all tag valids 0, add_valid 0, rsp_valid 0, add_a, add_b, add_cin, rsp_sum and rsp_cout 0.
REQ-019 Operations in flight at reset SHALL be discarded; no rsp_valid SHALL be produced for them after rst deassertion.
REQ-020 req_ready SHALL be 0 while rst=1.

Structure
REQ-021 Package cla_pkg SHALL hold the default W, N_REQ and LAT, the FSM state enum, and the id-width constant clog2(N_REQ).
REQ-022 The round-robin arbiter SHALL be sub-module cla_rr_arbiter, with inputs req and ptr and output one-hot grant; it SHALL be purely combinational.
REQ-023 Tag pipeline, counter, FSM and operand/response registers SHALL live in cla_sched.

Verification
REQ-024 Single request (W=128, LAT=4): req 2 sends a=1, b=all-ones, cin=0 in cycle t -> rsp_valid=4'b0100 in t+6, rsp_sum=0, rsp_cout=1.
REQ-025 All four req_valid held high, ptr=0 -> grants 0,1,2,3,0,1 on consecutive cycles; each response routed to the correct id with a+b+cin.
REQ-026 req_valid=4'b1010 with ptr=2 -> grant 3, then 1, then 3.
REQ-027 en dropped after 3 accepts -> req_ready=0 next cycle; FSM in DRAIN; 3 responses delivered; busy falls the cycle after the last response; FSM in IDLE.
REQ-028 rst pulsed with 3 in flight -> rsp_valid stays 0 for 10 cycles after release; first new request gets grant to the lowest valid id from ptr 0.
REQ-029 Random traffic, 10k cycles -> response count equals accept count; every sum correct; no starvation beyond N_REQ-1 cycles.
